// File: rtl/re_name_multi.sv
// Register renamer: per-arch-register name counters and in-flight writer counts that turn
// 5-bit architectural operands into {name, arch} physical tags and stall when rd has no free name.
package re_name_multi_pkg;
  localparam int unsigned REG_ADDR_SIZE = 8;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [7:0] {
    OP_ADD      = 8'd0,
    OP_FADD     = 8'd1,
    OP_FMADD    = 8'd2,
    OP_FCVT_F2I = 8'd3,
    OP_FCVT_I2F = 8'd4
  } fu_op_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_op_t                   op;
    logic [REG_ADDR_SIZE-1:0] rs1;
    logic [REG_ADDR_SIZE-1:0] rs2;
    logic [REG_ADDR_SIZE-1:0] rd;
    logic [XLEN-1:0]          result;
  } scoreboard_entry_t;

  function automatic logic is_rs1_fpr(input fu_op_t op);
    return op inside {OP_FADD, OP_FMADD, OP_FCVT_F2I};
  endfunction

  function automatic logic is_rs2_fpr(input fu_op_t op);
    return op inside {OP_FADD, OP_FMADD};
  endfunction

  // Third FP source (fmadd rs3) travels in the result field.
  function automatic logic is_imm_fpr(input fu_op_t op);
    return op == OP_FMADD;
  endfunction

  function automatic logic is_rd_fpr(input fu_op_t op);
    return op inside {OP_FADD, OP_FMADD, OP_FCVT_I2F};
  endfunction
endpackage

module re_name_multi
  import re_name_multi_pkg::*;
#(
  parameter int unsigned NAME_BITS       = 2,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter bit          EN_RENAME       = 1'b1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_i,
  input  logic                              flush_i,
  input  logic                              flush_unissied_instr_i,
  input  scoreboard_entry_t                 issue_instr_i,
  input  logic                              issue_instr_valid_i,
  output logic                              issue_ack_o,
  output scoreboard_entry_t                 issue_instr_o,
  output logic                              issue_instr_valid_o,
  input  logic                              issue_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]   commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]        commit_fpr_i,
  output logic                              rename_stall_o
);

  localparam int unsigned NR_ARCH = 32;
  localparam int unsigned CNT_W   = $clog2(NR_COMMIT_PORTS + 1);

  typedef logic [NAME_BITS-1:0] name_t;

  name_t            name_q [2][NR_ARCH];
  name_t            name_d [2][NR_ARCH];
  name_t            infl_q [2][NR_ARCH];
  name_t            infl_d [2][NR_ARCH];
  logic [CNT_W-1:0] commit_cnt [2][NR_ARCH];

  logic       rd_fpr, rs1_fpr, rs2_fpr, imm_fpr, rd_x0;
  logic [4:0] rd_idx, rs1_idx, rs2_idx, res_idx;
  name_t      rs1_name, rs2_name, res_name, rd_name_nxt;
  logic       stall, fire, rename_fire, underflow;
  int         nxt;

  function automatic logic [REG_ADDR_SIZE-1:0] mk_tag(input name_t name, input logic [4:0] idx);
    return REG_ADDR_SIZE'({name, idx});
  endfunction

  // Operand decode and pre-rename name lookup.
  assign rd_fpr  = is_rd_fpr(issue_instr_i.op);
  assign rs1_fpr = is_rs1_fpr(issue_instr_i.op);
  assign rs2_fpr = is_rs2_fpr(issue_instr_i.op);
  assign imm_fpr = is_imm_fpr(issue_instr_i.op);
  assign rd_idx  = issue_instr_i.rd[4:0];
  assign rs1_idx = issue_instr_i.rs1[4:0];
  assign rs2_idx = issue_instr_i.rs2[4:0];
  assign res_idx = issue_instr_i.result[4:0];
  assign rd_x0   = ~rd_fpr & (rd_idx == 5'd0);

  assign rs1_name    = EN_RENAME ? name_q[rs1_fpr][rs1_idx] : '0;
  assign rs2_name    = EN_RENAME ? name_q[rs2_fpr][rs2_idx] : '0;
  assign res_name    = EN_RENAME ? name_q[1][res_idx]       : '0;
  assign rd_name_nxt = EN_RENAME ? name_t'(name_q[rd_fpr][rd_idx] + name_t'(1)) : '0;

  // Every name of rd is still owned by an in-flight writer.
  assign stall = EN_RENAME & issue_instr_valid_i & ~rd_x0 & (infl_q[rd_fpr][rd_idx] == '1);

  assign issue_instr_valid_o = issue_instr_valid_i & ~stall;
  assign issue_ack_o         = issue_ack_i & ~stall;
  assign rename_stall_o      = stall;

  assign fire        = issue_ack_i & ~stall & ~flush_unissied_instr_i;
  assign rename_fire = fire & ~rd_x0 & EN_RENAME;

  // Renamed entry: everything passes through except the register tags.
  always_comb begin
    issue_instr_o     = issue_instr_i;
    issue_instr_o.rs1 = mk_tag(rs1_name, rs1_idx);
    issue_instr_o.rs2 = mk_tag(rs2_name, rs2_idx);
    if (imm_fpr) begin
      issue_instr_o.result = XLEN'(mk_tag(res_name, res_idx));
    end
    issue_instr_o.rd = rd_x0 ? '0 : mk_tag(rd_name_nxt, rd_idx);
  end

  // Number of retiring writers per register this cycle; GPR x0 never counts.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < NR_ARCH; r++) begin
        commit_cnt[f][r] = '0;
      end
    end
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (commit_valid_i[p] && !(!commit_fpr_i[p] && commit_rd_i[p] == 5'd0)) begin
        commit_cnt[commit_fpr_i[p]][commit_rd_i[p]] =
          commit_cnt[commit_fpr_i[p]][commit_rd_i[p]] + CNT_W'(1);
      end
    end
  end

  // Next name / in-flight state; flush wipes everything including this cycle's updates.
  always_comb begin
    name_d    = name_q;
    infl_d    = infl_q;
    underflow = 1'b0;
    nxt       = 0;
    if (rename_fire) begin
      name_d[rd_fpr][rd_idx] = rd_name_nxt;
    end
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < NR_ARCH; r++) begin
        nxt = int'(infl_q[f][r]) - int'(commit_cnt[f][r]);
        if (rename_fire && rd_fpr == 1'(f) && rd_idx == 5'(r)) begin
          nxt = nxt + 1;
        end
        if (nxt < 0) begin
          underflow    = 1'b1;
          infl_d[f][r] = '0;
        end else begin
          infl_d[f][r] = NAME_BITS'(nxt);
        end
      end
    end
    name_d[0][0] = '0;
    infl_d[0][0] = '0;
    if (flush_i || !EN_RENAME) begin
      name_d = '{default: '0};
      infl_d = '{default: '0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      name_q <= '{default: '0};
      infl_q <= '{default: '0};
    end else if (clr_i) begin
      name_q <= '{default: '0};
      infl_q <= '{default: '0};
    end else begin
      name_q <= name_d;
      infl_q <= infl_d;
    end
  end

  // More retirements than outstanding writers means the commit stream is broken.
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (clr_i || flush_i || !underflow));

endmodule
